// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor with a tagged branch target buffer.
//
// Maps the fetch PC to a predicted next PC each cycle (combinational) and reports the
// global-history snapshot used, which the pipeline carries to EX. EX-stage resolution trains
// the PHT/BTB and, on a mispredict, repairs the global history.
//
// Optional feature: define BP_RAS_EN to add a RAS_DEPTH-entry circular return address stack.
// Without it, calls and returns behave as plain jumps to the BTB target.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_if_pc, i_if_stall fetch PC; stall freezes speculative history/stack updates
//   o_pred_pc           predicted next fetch PC
//   o_pred_taken        prediction is a redirect
//   o_pred_ghr          global history used for this prediction
//   i_upd_*             EX-stage resolution: valid, pc, ghr snapshot, kind, taken, target,
//                       mispredict
module branch_predictor #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned GHR_BITS    = 5,
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] i_if_pc,
    input  logic                i_if_stall,
    output logic [PC_WIDTH-1:0] o_pred_pc,
    output logic                o_pred_taken,
    output logic [GHR_BITS-1:0] o_pred_ghr,
    input  logic                i_upd_valid,
    input  logic [PC_WIDTH-1:0] i_upd_pc,
    input  logic [GHR_BITS-1:0] i_upd_ghr,
    input  logic [1:0]          i_upd_kind,
    input  logic                i_upd_taken,
    input  logic [PC_WIDTH-1:0] i_upd_target,
    input  logic                i_upd_mispredict
);

    localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned TagW = PC_WIDTH - IdxW - 2;
    localparam int unsigned PhtN = 1 << GHR_BITS;

    localparam logic [1:0] KindCond = 2'd0;
    localparam logic [1:0] KindCall = 2'd2;
    localparam logic [1:0] KindRet  = 2'd3;

    logic                r_btb_valid  [BTB_ENTRIES];
    logic [TagW-1:0]     r_btb_tag    [BTB_ENTRIES];
    logic [PC_WIDTH-1:0] r_btb_target [BTB_ENTRIES];
    logic [1:0]          r_btb_kind   [BTB_ENTRIES];
    logic [1:0]          r_pht        [PhtN];
    logic [GHR_BITS-1:0] r_ghr;

    logic [IdxW-1:0]     w_if_idx;
    logic [TagW-1:0]     w_if_tag;
    logic [GHR_BITS-1:0] w_if_pht_idx;
    logic                w_hit;
    logic [1:0]          w_kind;
    logic                w_dir;
    logic                w_taken;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic                w_repair;
    logic [GHR_BITS-1:0] w_ghr_d;
    logic [IdxW-1:0]     w_upd_idx;
    logic [TagW-1:0]     w_upd_tag;
    logic [GHR_BITS-1:0] w_upd_pht_idx;
    logic [1:0]          w_pht_cur;
    logic [1:0]          w_pht_new;
    logic                w_unused;

    // Instruction-alignment bits never take part in indexing or tagging.
    assign w_unused = ^{i_if_pc[1:0], i_upd_pc[1:0]};

    // Lookup
    assign w_if_idx     = i_if_pc[IdxW+1:2];
    assign w_if_tag     = i_if_pc[PC_WIDTH-1:IdxW+2];
    assign w_if_pht_idx = i_if_pc[GHR_BITS+1:2] ^ r_ghr;
    assign w_hit        = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
    assign w_kind       = r_btb_kind[w_if_idx];
    assign w_dir        = r_pht[w_if_pht_idx][1];
    assign w_taken      = w_hit && ((w_kind != KindCond) || w_dir);
    assign w_seq_pc     = i_if_pc + PC_WIDTH'(4);
    assign w_repair     = i_upd_valid && i_upd_mispredict;

    assign o_pred_taken = w_taken;
    assign o_pred_ghr   = r_ghr;

    // Repair is applied last so it overrides a same-cycle speculative shift.
    always_comb begin
        w_ghr_d = r_ghr;
        if (!i_if_stall && w_hit && (w_kind == KindCond)) begin
            w_ghr_d = {r_ghr[GHR_BITS-2:0], w_dir};
        end
        if (w_repair) begin
            if (i_upd_kind == KindCond) begin
                w_ghr_d = {i_upd_ghr[GHR_BITS-2:0], i_upd_taken};
            end else begin
                w_ghr_d = i_upd_ghr;
            end
        end
    end

    // Training
    assign w_upd_idx     = i_upd_pc[IdxW+1:2];
    assign w_upd_tag     = i_upd_pc[PC_WIDTH-1:IdxW+2];
    assign w_upd_pht_idx = i_upd_pc[GHR_BITS+1:2] ^ i_upd_ghr;
    assign w_pht_cur     = r_pht[w_upd_pht_idx];

    always_comb begin
        w_pht_new = w_pht_cur;
        if (i_upd_taken) begin
            if (w_pht_cur != 2'd3) w_pht_new = w_pht_cur + 2'd1;
        end else begin
            if (w_pht_cur != 2'd0) w_pht_new = w_pht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
            end
            for (int unsigned i = 0; i < PhtN; i++) begin
                r_pht[i] <= 2'b01;
            end
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_d;
            if (i_upd_valid && (i_upd_kind == KindCond)) begin
                r_pht[w_upd_pht_idx] <= w_pht_new;
            end
            // Only taken outcomes allocate; the occupant is always replaced.
            if (i_upd_valid && i_upd_taken) begin
                r_btb_valid[w_upd_idx]  <= 1'b1;
                r_btb_tag[w_upd_idx]    <= w_upd_tag;
                r_btb_target[w_upd_idx] <= i_upd_target;
                r_btb_kind[w_upd_idx]   <= i_upd_kind;
            end
        end
    end

`ifdef BP_RAS_EN
    localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RasCntW = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [RasPtrW-1:0]  r_ras_ptr;   // next free slot
    logic [RasCntW-1:0]  r_ras_cnt;
    logic [RasPtrW-1:0]  w_ras_top;
    logic [RasPtrW-1:0]  w_ras_next;
    logic                w_ras_use;
    logic                w_push;
    logic                w_pop;

    assign w_ras_top  = (r_ras_ptr == '0) ? RasPtrW'(RAS_DEPTH - 1) : r_ras_ptr - 1'b1;
    assign w_ras_next = (r_ras_ptr == RasPtrW'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + 1'b1;
    assign w_ras_use  = w_hit && (w_kind == KindRet) && (r_ras_cnt != '0);
    assign w_push     = !i_if_stall && w_hit && (w_kind == KindCall) && !w_repair;
    assign w_pop      = !i_if_stall && w_ras_use && !w_repair;

    assign o_pred_pc = !w_taken  ? w_seq_pc :
                       w_ras_use ? r_ras[w_ras_top] : r_btb_target[w_if_idx];

    always_ff @(posedge clk) begin
        if (reset || w_repair) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_push) begin
            // Full stack: the oldest slot is the one being overwritten.
            r_ras[r_ras_ptr] <= w_seq_pc;
            r_ras_ptr        <= w_ras_next;
            if (r_ras_cnt != RasCntW'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + 1'b1;
        end else if (w_pop) begin
            r_ras_ptr <= w_ras_top;
            r_ras_cnt <= r_ras_cnt - 1'b1;
        end
    end
`else
    assign o_pred_pc = w_taken ? r_btb_target[w_if_idx] : w_seq_pc;
`endif

endmodule
